// File: rtl/dict_pkg.sv
// Shared dictionary-image definitions: header layout, count width, loader states
// and the default dictionary geometry used by the loader and the controller.
package dict_pkg;

  localparam int COUNT_W    = 8;
  localparam int HDR_N1_LSB = 0;
  localparam int HDR_N2_LSB = 8;
  localparam int HDR_N3_LSB = 16;

  localparam int DICT1_KEY_W = 3;
  localparam int DICT2_KEY_W = 5;
  localparam int DICT3_KEY_W = 8;
  localparam int DICT1_VAL_W = 7;
  localparam int DICT2_VAL_W = 10;
  localparam int DICT3_VAL_W = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD1,
    S_LOAD2,
    S_LOAD3,
    S_DONE
  } state_t;

  // A dictionary with key width kw holds 2^kw entries; larger header counts are clipped.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] cnt,
                                                     input int key_w);
    if (key_w < COUNT_W && int'(cnt) > (1 << key_w)) return COUNT_W'(1 << key_w);
    return cnt;
  endfunction

endpackage

// File: rtl/dict_mem_mux.sv
// Hands the memory port to the controller once loading is done; until then the
// loader owns it and the controller sees no ready and zero data.
module dict_mem_mux (
  input  logic        sel,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic        ctrl_ready,
  output logic [31:0] ctrl_rdata
);

  assign mem_valid  = sel ? ctrl_valid : ld_valid;
  assign mem_addr   = sel ? ctrl_addr  : ld_addr;
  assign ctrl_ready = sel & mem_ready;
  assign ctrl_rdata = sel ? mem_rdata : '0;

endmodule

// File: rtl/dict_loader.sv
// Boot-time loader: reads the dictionary image header, then streams each
// dictionary's values into its write port before releasing memory to the controller.
module dict_loader import dict_pkg::*; #(
  parameter int          FIELD1_KEY_WIDTH = DICT1_KEY_W,
  parameter int          FIELD2_KEY_WIDTH = DICT2_KEY_W,
  parameter int          FIELD3_KEY_WIDTH = DICT3_KEY_W,
  parameter int          FIELD1_VAL_WIDTH = DICT1_VAL_W,
  parameter int          FIELD2_VAL_WIDTH = DICT2_VAL_W,
  parameter int          FIELD3_VAL_WIDTH = DICT3_VAL_W,
  parameter logic [31:0] DICT_BASE_ADDR   = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        proc_valid_in,
  output logic                        proc_valid_out,
  input  logic                        ctrl_mem_req_valid,
  input  logic [31:0]                 ctrl_mem_req_addr,
  output logic                        ctrl_mem_req_ready,
  output logic [31:0]                 ctrl_mem_req_rdata,
  output logic                        mem_req_valid,
  output logic [31:0]                 mem_req_addr,
  input  logic                        mem_req_ready,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

  state_t             state;
  logic [COUNT_W-1:0] n1, n2, n3;
  logic [15:0]        idx;
  logic               ld_valid;
  logic [31:0]        ld_addr;

  logic [COUNT_W-1:0] c1, c2, c3, cur_rem;
  state_t             hdr_next, load_next;
  logic [31:0]        word_addr;

  assign c1 = clamp_count(mem_req_rdata[HDR_N1_LSB +: COUNT_W], FIELD1_KEY_WIDTH);
  assign c2 = clamp_count(mem_req_rdata[HDR_N2_LSB +: COUNT_W], FIELD2_KEY_WIDTH);
  assign c3 = clamp_count(mem_req_rdata[HDR_N3_LSB +: COUNT_W], FIELD3_KEY_WIDTH);
  assign word_addr = DICT_BASE_ADDR + {14'd0, idx, 2'b00};

  // Empty dictionaries are skipped by jumping straight to the next non-empty one.
  always_comb begin
    hdr_next  = S_DONE;
    load_next = S_DONE;
    cur_rem   = '0;
    if (c3 != '0) hdr_next = S_LOAD3;
    if (c2 != '0) hdr_next = S_LOAD2;
    if (c1 != '0) hdr_next = S_LOAD1;
    case (state)
      S_LOAD1: begin
        cur_rem = n1;
        if (n3 != '0) load_next = S_LOAD3;
        if (n2 != '0) load_next = S_LOAD2;
      end
      S_LOAD2: begin
        cur_rem = n2;
        if (n3 != '0) load_next = S_LOAD3;
      end
      S_LOAD3: cur_rem = n3;
      default: ;
    endcase
  end

  // NOTE: all state here updates with <= so every branch sees the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      n1                 <= '0;
      n2                 <= '0;
      n3                 <= '0;
      idx                <= '0;
      ld_valid           <= 1'b0;
      ld_addr            <= '0;
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_val    <= '0;
      dict3_write_val    <= '0;
    end else begin
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_HDR;
          busy     <= 1'b1;
          ld_valid <= 1'b1;
          ld_addr  <= DICT_BASE_ADDR;
          idx      <= 16'd1;
        end
        S_HDR: if (ld_valid && mem_req_ready) begin
          ld_valid <= 1'b0;
          n1       <= c1;
          n2       <= c2;
          n3       <= c3;
          state    <= hdr_next;
          if (hdr_next == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        S_LOAD1, S_LOAD2, S_LOAD3: begin
          if (ld_valid) begin
            if (mem_req_ready) begin
              ld_valid <= 1'b0;
              idx      <= idx + 16'd1;
              case (state)
                S_LOAD1: begin
                  n1                 <= n1 - 8'd1;
                  dict1_write_enable <= 1'b1;
                  dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                end
                S_LOAD2: begin
                  n2                 <= n2 - 8'd1;
                  dict2_write_enable <= 1'b1;
                  dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                end
                default: begin
                  n3                 <= n3 - 8'd1;
                  dict3_write_enable <= 1'b1;
                  dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                end
              endcase
            end
          end else if (cur_rem == '0) begin
            // Reached only in the cycle after the last strobe of this dictionary.
            state <= load_next;
            if (load_next == S_DONE) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end else begin
            ld_valid <= 1'b1;
            ld_addr  <= word_addr;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign proc_valid_out = proc_valid_in & done;

  dict_mem_mux u_mux (
    .sel        (done),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ctrl_valid (ctrl_mem_req_valid),
    .ctrl_addr  (ctrl_mem_req_addr),
    .mem_ready  (mem_req_ready),
    .mem_rdata  (mem_req_rdata),
    .mem_valid  (mem_req_valid),
    .mem_addr   (mem_req_addr),
    .ctrl_ready (ctrl_mem_req_ready),
    .ctrl_rdata (ctrl_mem_req_rdata)
  );

endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: table vectors, hand-written reset/start
// sequences and random headers compared against an image-level reference model.
module tb_dict_loader;

  localparam logic [31:0] BASE      = 32'h0001_0000;
  localparam logic [31:0] CTRL_ADDR = 32'h8000_0040;
  localparam int CAP1 = 8, CAP2 = 32, CAP3 = 256;

  logic        clk, reset, start, busy, done;
  logic        proc_valid_in, proc_valid_out;
  logic        ctrl_mem_req_valid, ctrl_mem_req_ready;
  logic [31:0] ctrl_mem_req_addr, ctrl_mem_req_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [9:0]  dict2_write_val;
  logic [14:0] dict3_write_val;

  dict_loader dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .proc_valid_in(proc_valid_in), .proc_valid_out(proc_valid_out),
    .ctrl_mem_req_valid(ctrl_mem_req_valid), .ctrl_mem_req_addr(ctrl_mem_req_addr),
    .ctrl_mem_req_ready(ctrl_mem_req_ready), .ctrl_mem_req_rdata(ctrl_mem_req_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_req_rdata(mem_req_rdata),
    .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
    .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
    .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Memory image; words outside it return an address-derived pattern.
  logic [31:0] img [0:1023];
  int mem_lat = 2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a >= BASE && off[31:2] < 1024 && off[1:0] == 2'b00) return img[off[11:2]];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory responder: ready pulses mem_lat cycles after valid is first seen.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || mem_req_ready) begin
        mem_req_ready = 1'b0;
        wcnt = 0;
      end else if (mem_req_valid) begin
        if (wcnt >= mem_lat) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = mem_word(mem_req_addr);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: records reads and strobes, flags protocol and gating errors.
  logic [31:0] rd_addrs[$];
  logic [63:0] w1[$], w2[$], w3[$];
  int proto_err = 0, strobe_err = 0, gate_err = 0;
  int cyc = 0, hdr_cyc = -1, done_cyc = -1, ns;
  logic prev_valid = 0, prev_ready = 0, prev_done = 0, prev_ld_rdy = 0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_valid = 0; prev_ready = 0; prev_done = 0; prev_ld_rdy = 0;
    end else begin
      ns = int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable);
      if (ns > 1) strobe_err++;
      if (ns > 0 && !prev_ld_rdy) strobe_err++;
      if (dict1_write_enable) w1.push_back(64'(dict1_write_val));
      if (dict2_write_enable) w2.push_back(64'(dict2_write_val));
      if (dict3_write_enable) w3.push_back(64'(dict3_write_val));
      if (!done) begin
        if (proc_valid_out || ctrl_mem_req_ready || ctrl_mem_req_rdata != '0) gate_err++;
        if (mem_req_valid && mem_req_addr == CTRL_ADDR) gate_err++;
        if (prev_valid && !prev_ready && (!mem_req_valid || mem_req_addr != prev_addr)) proto_err++;
        if (prev_valid && prev_ready && mem_req_valid) proto_err++;
        if (mem_req_valid && mem_req_ready) begin
          rd_addrs.push_back(mem_req_addr);
          if (rd_addrs.size() == 1) hdr_cyc = cyc;
        end
      end
      if (done && !prev_done) done_cyc = cyc;
      prev_ld_rdy = !done && mem_req_valid && mem_req_ready && mem_req_addr != BASE;
      prev_valid  = mem_req_valid && !done;
      prev_ready  = mem_req_ready;
      prev_addr   = mem_req_addr;
      prev_done   = done;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_log();
    rd_addrs.delete(); w1.delete(); w2.delete(); w3.delete();
    proto_err = 0; strobe_err = 0; gate_err = 0; hdr_cyc = -1; done_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick(); tick();
    clear_log();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_image(input logic [31:0] hdr);
    img[0] = hdr;
    for (int i = 1; i < 1024; i++) img[i] = $urandom;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, 64'(busy), 0);
    check({tag, " done"}, 64'(done), 0);
    check({tag, " mem_req_valid"}, 64'(mem_req_valid), 0);
    check({tag, " mem_req_addr"}, 64'(mem_req_addr), 0);
    check({tag, " write enables"},
          64'({dict1_write_enable, dict2_write_enable, dict3_write_enable}), 0);
    check({tag, " write vals"}, 64'({dict1_write_val, dict2_write_val, dict3_write_val}), 0);
    check({tag, " ctrl ready"}, 64'(ctrl_mem_req_ready), 0);
  endtask

  // Start a load (optionally after a fresh reset) and compare against the image model.
  task automatic run_load(input string tag, input int e1, input int e2, input int e3,
                          input bit noise, input bit fresh);
    int k, base_i;
    if (fresh) do_reset();
    pulse_start();
    if (noise) begin
      for (k = 0; k < 4000 && w2.size() == 0; k++) tick();
      pulse_start();
    end
    for (k = 0; k < 5000 && !done; k++) tick();
    if (!done) begin
      check({tag, " done timeout"}, 64'(done), 1);
      return;
    end
    check({tag, " dict1 count"}, 64'(w1.size()), 64'(e1));
    check({tag, " dict2 count"}, 64'(w2.size()), 64'(e2));
    check({tag, " dict3 count"}, 64'(w3.size()), 64'(e3));
    for (int i = 0; i < e1 && i < w1.size(); i++)
      check($sformatf("%s dict1[%0d]", tag, i), w1[i], 64'(img[1 + i][6:0]));
    base_i = 1 + e1;
    for (int i = 0; i < e2 && i < w2.size(); i++)
      check($sformatf("%s dict2[%0d]", tag, i), w2[i], 64'(img[base_i + i][9:0]));
    base_i = 1 + e1 + e2;
    for (int i = 0; i < e3 && i < w3.size(); i++)
      check($sformatf("%s dict3[%0d]", tag, i), w3[i], 64'(img[base_i + i][14:0]));
    check({tag, " read count"}, 64'(rd_addrs.size()), 64'(1 + e1 + e2 + e3));
    for (int i = 0; i < rd_addrs.size(); i++)
      check($sformatf("%s addr[%0d]", tag, i), 64'(rd_addrs[i]), 64'(BASE + 32'(4 * i)));
    check({tag, " busy after done"}, 64'(busy), 0);
    if (e1 + e2 + e3 == 0)
      check({tag, " done latency"}, 64'(done_cyc - hdr_cyc), 1);
    check({tag, " handshake errors"}, 64'(proto_err), 0);
    check({tag, " strobe errors"}, 64'(strobe_err), 0);
    check({tag, " gating errors"}, 64'(gate_err), 0);
    check({tag, " proc_valid_out"}, 64'(proc_valid_out), 1);
    check({tag, " fwd valid"}, 64'(mem_req_valid), 1);
    check({tag, " fwd addr"}, 64'(mem_req_addr), 64'(CTRL_ADDR));
    for (k = 0; k < 20 && !ctrl_mem_req_ready; k++) tick();
    check({tag, " ctrl ready"}, 64'(ctrl_mem_req_ready), 1);
    check({tag, " ctrl rdata"}, 64'(ctrl_mem_req_rdata), 64'(mem_word(CTRL_ADDR)));
    if (noise) begin
      pulse_start();
      repeat (4) tick();
      check({tag, " done sticky"}, 64'({done, busy}), 64'(2'b10));
      check({tag, " no reload"}, 64'(w1.size() + w2.size() + w3.size()), 64'(e1 + e2 + e3));
    end
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          lat;
    int          e1, e2, e3;
    bit          noise;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e1, e2, e3, nr;
    logic [31:0] hdr;

    vecs[0] = '{32'h0001_0203, 2, 3, 2, 1, 1'b1};
    vecs[1] = '{32'h0000_0000, 2, 0, 0, 0, 1'b0};
    vecs[2] = '{32'h0001_0009, 1, 8, 0, 1, 1'b0};
    vecs[3] = '{32'hFF00_0500, 0, 0, 5, 0, 1'b0};
    vecs[4] = '{32'h0003_0002, 0, 2, 0, 3, 1'b0};
    vecs[5] = '{32'h0000_2808, 3, 8, 32, 0, 1'b0};

    reset = 1'b1; start = 1'b0;
    proc_valid_in = 1'b1; ctrl_mem_req_valid = 1'b1; ctrl_mem_req_addr = CTRL_ADDR;
    tick(); tick();
    check_reset_values("por");
    reset = 1'b0;
    tick();
    check_reset_values("idle");

    foreach (vecs[v]) begin
      set_image(vecs[v].hdr);
      mem_lat = vecs[v].lat;
      run_load($sformatf("vec%0d", v), vecs[v].e1, vecs[v].e2, vecs[v].e3, vecs[v].noise, 1'b1);
    end

    // Reset while the second dict1 read is being accepted: its strobe must never appear.
    set_image(32'h0001_0203);
    mem_lat = 2;
    do_reset();
    pulse_start();
    nr = 0;
    for (int k = 0; k < 500 && nr < 3; k++) begin
      tick();
      if (mem_req_valid && mem_req_ready && !done) nr++;
    end
    check("midreset reached", 64'(nr), 3);
    #1 reset = 1'b1;
    #1 check_reset_values("midreset async");
    tick(); tick(); tick();
    check("midreset dict1 strobes", 64'(w1.size()), 1);
    check("midreset other strobes", 64'(w2.size() + w3.size()), 0);
    clear_log();
    reset = 1'b0;
    tick();
    run_load("reload", 3, 2, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      hdr = {8'($urandom), 8'($urandom_range(0, 20)), 8'($urandom_range(0, 40)),
             8'($urandom_range(0, 15))};
      e1 = (int'(hdr[7:0])   > CAP1) ? CAP1 : int'(hdr[7:0]);
      e2 = (int'(hdr[15:8])  > CAP2) ? CAP2 : int'(hdr[15:8]);
      e3 = (int'(hdr[23:16]) > CAP3) ? CAP3 : int'(hdr[23:16]);
      set_image(hdr);
      mem_lat = $urandom_range(0, 3);
      run_load($sformatf("rand%0d hdr=%h", r, hdr), e1, e2, e3, 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
